// File: rtl/mult_pkg.sv
// Shared types and sizes for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  localparam int ITER_COUNT = 8;
  localparam int OP_W       = 8;

endpackage

// File: rtl/eight_bit_adder.sv
// 8-bit ripple-carry adder; purely combinational, one full-adder cell per bit.
module eight_bit_adder
  import mult_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic            cin,
  output logic [OP_W-1:0] s,
  output logic            cout
);

  logic [OP_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < OP_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[OP_W];

endmodule

// File: rtl/shift_add_multiplier.sv
// 8x8 add-and-shift multiplier, 8 cycles accept->out_valid; holds DONE until out_ready, in_ready only in IDLE.
// Define SIGNED_MULT_EN for two's-complement operands (final iteration subtracts the multiplicand).
module shift_add_multiplier
  import mult_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OP_W-1:0] P
);

  mult_state_t     state;
  logic [OP_W-1:0] m;
  logic [OP_W-1:0] ah;
  logic [OP_W-1:0] bl;
  logic [2:0]      cnt;

  logic [OP_W-1:0] add_b;
  logic [OP_W-1:0] s;
  logic            cin;
  logic            cout;
  logic            xn;
  logic            last;

  assign last     = (cnt == 3'(ITER_COUNT - 1));
  assign in_ready = (state == IDLE);

`ifdef SIGNED_MULT_EN
  logic            x;
  logic [OP_W-1:0] mp;

  // Last partial product carries negative weight, so it is subtracted.
  assign mp    = last ? ~m : m;
  assign cin   = last & bl[0];
  assign add_b = bl[0] ? mp : '0;
  // x mirrors the sign of ah, so this is the true 9th bit of {x,ah}+{mp[7],mp}.
  assign xn    = bl[0] ? (x ^ mp[OP_W-1] ^ cout) : x;
`else
  assign cin   = 1'b0;
  assign add_b = bl[0] ? m : '0;
  // The carry out shifts straight into the top of the high half.
  assign xn    = cout;
`endif

  eight_bit_adder u_add (
    .a    (ah),
    .b    (add_b),
    .cin  (cin),
    .s    (s),
    .cout (cout)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      m         <= '0;
      ah        <= '0;
      bl        <= '0;
      cnt       <= '0;
      P         <= '0;
      out_valid <= 1'b0;
`ifdef SIGNED_MULT_EN
      x         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            m     <= A;
            bl    <= B;
            ah    <= '0;
            cnt   <= '0;
            state <= RUN;
`ifdef SIGNED_MULT_EN
            x     <= 1'b0;
`endif
          end
        end
        RUN: begin
          ah  <= {xn, s[OP_W-1:1]};
          bl  <= {s[0], bl[OP_W-1:1]};
          cnt <= cnt + 3'd1;
`ifdef SIGNED_MULT_EN
          x   <= xn;
`endif
          if (last) begin
            P         <= {xn, s, bl[OP_W-1:1]};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier; expectations follow SIGNED_MULT_EN.
module tb_shift_add_multiplier;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] P;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SIGNED_MULT_EN
  localparam logic [15:0] E_FF_FF = 16'h0001;
  localparam logic [15:0] E_80_7F = 16'hC080;
  localparam logic [15:0] E_07_FD = 16'hFFEB;
`else
  localparam logic [15:0] E_FF_FF = 16'hFE01;
  localparam logic [15:0] E_80_7F = 16'h3F80;
  localparam logic [15:0] E_07_FD = 16'h06EB;
`endif

  always #5 Clk = ~Clk;

  shift_add_multiplier dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic accept(input string tag, input logic [7:0] a, input logic [7:0] b);
    int w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    check({tag, "_in_ready"}, 16'(in_ready), 16'd1);
    A        = a;
    B        = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    A        = 8'h00;
    B        = 8'h00;
    check({tag, "_busy"}, 16'(in_ready), 16'd0);
  endtask

  task automatic wait_done(input string tag, input logic [15:0] exp);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 16'(lat), 16'd8);
    check({tag, "_P"}, P, exp);
  endtask

  task automatic release_out(input string tag, input logic [15:0] exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, 16'(out_valid), 16'd0);
    check({tag, "_idle"}, 16'(in_ready), 16'd1);
    check({tag, "_P_hold"}, P, exp);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    accept(tag, a, b);
    wait_done(tag, exp);
    release_out(tag, exp);
  endtask

  initial begin
    Reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = 8'h00;
    B         = 8'h00;
    #12;
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_P", P, 16'h0000);
    Reset_n = 1'b1;
    step();

    run_op("ff_ff", 8'hFF, 8'hFF, E_FF_FF);
    run_op("00_5a", 8'h00, 8'h5A, 16'h0000);
    run_op("5a_01", 8'h5A, 8'h01, 16'h005A);
    run_op("80_7f", 8'h80, 8'h7F, E_80_7F);

    // Consumer stalls in DONE while the source keeps offering operands.
    accept("hold", 8'h07, 8'hFD);
    wait_done("hold", E_07_FD);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      A        = 8'(i * 17 + 1);
      B        = 8'hC3;
      step();
      check("hold_P", P, E_07_FD);
      check("hold_in_ready", 16'(in_ready), 16'd0);
      check("hold_out_valid", 16'(out_valid), 16'd1);
    end
    in_valid = 1'b0;
    A        = 8'h00;
    B        = 8'h00;
    release_out("hold", E_07_FD);
    step();
    check("hold_no_restart", 16'(in_ready), 16'd1);
    run_op("after_hold", 8'h5A, 8'h01, 16'h005A);

    // Reset in the middle of an operation, after four RUN edges.
    accept("abort", 8'h33, 8'h44);
    for (int i = 0; i < 4; i++) step();
    check("abort_running", 16'(out_valid), 16'd0);
    #1 Reset_n = 1'b0;
    #1;
    check("abort_out_valid", 16'(out_valid), 16'd0);
    check("abort_P", P, 16'h0000);
    check("abort_in_ready", 16'(in_ready), 16'd1);
    #1 Reset_n = 1'b1;
    step();
    check("abort_stay_idle", 16'(out_valid), 16'd0);
    run_op("3x5", 8'h03, 8'h05, 16'h000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
